// File: rtl/adc_avg_sampler_pkg.sv
// Shared constants for the ADC averaging sampler: CSR word map, CTRL bit
// positions and the drop-counter width with its saturating increment.
package adc_avg_pkg;

    localparam logic [4:0] CSR_CTRL  = 5'd0;
    localparam logic [4:0] CSR_NEW   = 5'd1;
    localparam logic [4:0] CSR_ALARM = 5'd2;
    localparam logic [4:0] CSR_DROP  = 5'd3;

    localparam int CSR_RESULT_BASE = 4;
    localparam int CSR_THRESH_BASE = 20;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLEAR  = 2;

    localparam int DROP_W = 16;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/adc_avg_sampler_if.sv
// Bus bundle for the sampler: ADC response stream (no backpressure) plus the
// Avalon-MM CSR port. The fabric side is master, the sampler is slave.
interface adc_avg_sampler_if #(
    parameter int DATA_W = 12,
    parameter int CH_W   = 5
);
    logic              response_valid;
    logic [CH_W-1:0]   response_channel;
    logic [DATA_W-1:0] response_data;
    logic [4:0]        csr_address;
    logic              csr_read;
    logic              csr_write;
    logic [31:0]       csr_writedata;
    logic [31:0]       csr_readdata;

    modport master (
        output response_valid, response_channel, response_data,
        output csr_address, csr_read, csr_write, csr_writedata,
        input  csr_readdata
    );

    modport slave (
        input  response_valid, response_channel, response_data,
        input  csr_address, csr_read, csr_write, csr_writedata,
        output csr_readdata
    );
endinterface

// File: rtl/adc_avg_sampler_csr.sv
// CSR bank of the averaging sampler: CTRL, W1C NEW/ALARM flags with set
// priority, saturating drop counter, thresholds and a registered read mux.
module adc_avg_csr
    import adc_avg_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 12
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [4:0]                     i_address,
    input  logic                           i_read,
    input  logic                           i_write,
    input  logic [31:0]                    i_writedata,
    output logic [31:0]                    o_readdata,
    input  logic [NUM_CH-1:0]              i_set_new,
    input  logic [NUM_CH-1:0]              i_set_alarm,
    input  logic                           i_drop,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  i_result,
    output logic                           o_enable,
    output logic                           o_clear,
    output logic [NUM_CH-1:0][DATA_W-1:0]  o_thresh,
    output logic                           o_irq
);

    logic                          r_enable;
    logic                          r_irq_en;
    logic [NUM_CH-1:0]             r_new;
    logic [NUM_CH-1:0]             r_alarm;
    logic [DROP_W-1:0]             r_drop;
    logic [NUM_CH-1:0][DATA_W-1:0] r_thresh;
    logic [31:0]                   r_readdata;

    logic              w_wr_ctrl;
    logic              w_wr_new;
    logic              w_wr_alarm;
    logic              w_wr_drop;
    logic [NUM_CH-1:0] w_new_clr;
    logic [NUM_CH-1:0] w_alarm_clr;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_wr_ctrl   = i_write & (i_address == CSR_CTRL);
    assign w_wr_new    = i_write & (i_address == CSR_NEW);
    assign w_wr_alarm  = i_write & (i_address == CSR_ALARM);
    assign w_wr_drop   = i_write & (i_address == CSR_DROP);
    assign w_new_clr   = w_wr_new   ? i_writedata[NUM_CH-1:0] : '0;
    assign w_alarm_clr = w_wr_alarm ? i_writedata[NUM_CH-1:0] : '0;
    assign w_unused    = ^i_writedata;

    assign o_clear    = w_wr_ctrl & i_writedata[CTRL_CLEAR];
    assign o_enable   = r_enable;
    assign o_thresh   = r_thresh;
    assign o_readdata = r_readdata;
    assign o_irq      = r_irq_en & (|r_alarm);

    // Read mux; per-channel windows are OR-ed in so unmapped words fall out as 0.
    always_comb begin
        w_rdata = 32'd0;
        case (i_address)
            CSR_CTRL:  w_rdata = {30'd0, r_irq_en, r_enable};
            CSR_NEW:   w_rdata = 32'(r_new);
            CSR_ALARM: w_rdata = 32'(r_alarm);
            CSR_DROP:  w_rdata = 32'(r_drop);
            default: begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    w_rdata = w_rdata
                        | ((int'(i_address) == CSR_RESULT_BASE + ch) ? 32'(i_result[ch]) : 32'd0)
                        | ((int'(i_address) == CSR_THRESH_BASE + ch) ? 32'(r_thresh[ch]) : 32'd0);
                end
            end
        endcase
    end

    // Control, flag and counter state; a new event beats a same-cycle W1C.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_enable <= 1'b0;
            r_irq_en <= 1'b0;
            r_new    <= '0;
            r_alarm  <= '0;
            r_drop   <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_enable <= i_writedata[CTRL_ENABLE];
                r_irq_en <= i_writedata[CTRL_IRQ_EN];
            end
            if (o_clear) begin
                r_new   <= '0;
                r_alarm <= '0;
                r_drop  <= '0;
            end else begin
                r_new   <= (r_new & ~w_new_clr) | i_set_new;
                r_alarm <= (r_alarm & ~w_alarm_clr) | i_set_alarm;
                if (w_wr_drop) begin
                    r_drop <= '0;
                end else if (i_drop) begin
                    r_drop <= sat_inc(r_drop);
                end
            end
        end
    end

    // Threshold bank and registered read data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_thresh   <= '1;
            r_readdata <= 32'd0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (i_write && (int'(i_address) == CSR_THRESH_BASE + ch)) begin
                    r_thresh[ch] <= i_writedata[DATA_W-1:0];
                end
            end
            if (i_read) begin
                r_readdata <= w_rdata;
            end
        end
    end

endmodule

// File: rtl/adc_avg_sampler.sv
// Per-channel averaging and threshold monitor on the ADC response stream.
// One shared adder serves the channel addressed by the current sample.
module adc_avg_sampler
    import adc_avg_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int DATA_W   = 12,
    parameter int CH_W     = 5,
    parameter int LOG2_AVG = 4
) (
    input  logic               clock_clk,
    input  logic               reset_sink_reset_n,
    adc_avg_sampler_if.slave   bus,
    output logic               irq
);

    localparam int SUM_W = DATA_W + LOG2_AVG;
    localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // With LOG2_AVG=0 this is 0, so every sample closes its window.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << LOG2_AVG) - 1);

    logic [SUM_W-1:0]              r_acc [NUM_CH];
    logic [CNT_W-1:0]              r_cnt [NUM_CH];
    logic [NUM_CH-1:0][DATA_W-1:0] r_result;

    logic                          w_enable;
    logic                          w_clear;
    logic [NUM_CH-1:0][DATA_W-1:0] w_thresh;
    logic                          w_ch_ok;
    logic [IDX_W-1:0]              w_idx;
    logic                          w_live;
    logic                          w_take;
    logic                          w_drop;
    logic [SUM_W-1:0]              w_sum;
    logic                          w_done;
    logic [DATA_W-1:0]             w_avg;
    logic [NUM_CH-1:0]             w_set_new;
    logic [NUM_CH-1:0]             w_set_alarm;

    assign w_ch_ok = 32'(bus.response_channel) < NUM_CH;
    assign w_idx   = w_ch_ok ? IDX_W'(bus.response_channel) : '0;
    assign w_live  = bus.response_valid & w_enable & ~w_clear;
    assign w_take  = w_live & w_ch_ok;
    assign w_drop  = w_live & ~w_ch_ok;
    assign w_sum   = r_acc[w_idx] + SUM_W'(bus.response_data);
    assign w_done  = (r_cnt[w_idx] == CNT_MAX);
    assign w_avg   = w_sum[SUM_W-1:LOG2_AVG];

    // Window-complete events for the flag bank; compare uses the pre-write threshold.
    always_comb begin
        w_set_new   = '0;
        w_set_alarm = '0;
        if (w_take && w_done) begin
            w_set_new[w_idx]   = 1'b1;
            w_set_alarm[w_idx] = (w_avg > w_thresh[w_idx]);
        end else begin
            w_set_new   = '0;
            w_set_alarm = '0;
        end
    end

    // Accumulators, window counters and published averages.
    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_acc[ch] <= '0;
                r_cnt[ch] <= '0;
            end
            r_result <= '0;
        end else if (w_clear) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_acc[ch] <= '0;
                r_cnt[ch] <= '0;
            end
        end else if (w_take) begin
            if (w_done) begin
                r_result[w_idx] <= w_avg;
                r_acc[w_idx]    <= '0;
                r_cnt[w_idx]    <= '0;
            end else begin
                r_acc[w_idx] <= w_sum;
                r_cnt[w_idx] <= r_cnt[w_idx] + CNT_W'(1);
            end
        end
    end

    adc_avg_csr #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W)
    ) u_csr (
        .i_clk       (clock_clk),
        .i_rst_n     (reset_sink_reset_n),
        .i_address   (bus.csr_address),
        .i_read      (bus.csr_read),
        .i_write     (bus.csr_write),
        .i_writedata (bus.csr_writedata),
        .o_readdata  (bus.csr_readdata),
        .i_set_new   (w_set_new),
        .i_set_alarm (w_set_alarm),
        .i_drop      (w_drop),
        .i_result    (r_result),
        .o_enable    (w_enable),
        .o_clear     (w_clear),
        .o_thresh    (w_thresh),
        .o_irq       (irq)
    );

endmodule
